// File: rtl/mf_clkgen_pkg.sv
// mf_clkgen_pkg: shared definitions for the multi-channel fractional
// clock-enable generator.
//   CFG_INC / CFG_PHASE : cfg_sel encodings (increment / phase register)
//   CH_IDX_W            : width of the cfg_ch channel index
//   lock_state_e        : lock FSM states
package mf_clkgen_pkg;

  localparam logic CFG_INC   = 1'b0;
  localparam logic CFG_PHASE = 1'b1;

  localparam int CH_IDX_W = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/mf_clkgen_nco.sv
// mf_clkgen_nco: one phase-accumulator channel.
// Ports:
//   clk      in   reference clock
//   rst      in   synchronous active-high reset
//   realign  in   load acc from phase (bank-wide realign on a valid write)
//   inc_wr   in   write strobe for the increment register
//   phase_wr in   write strobe for the phase register
//   wr_data  in   ACC_W-bit value for either write
//   en_raw   out  registered carry of acc + inc (one-cycle pulse)
//   clk_raw  out  registered MSB of the new accumulator value
module mf_clkgen_nco #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             realign,
  input  logic             inc_wr,
  input  logic             phase_wr,
  input  logic [ACC_W-1:0] wr_data,
  output logic             en_raw,
  output logic             clk_raw
);

  logic [ACC_W-1:0] inc_r;
  logic [ACC_W-1:0] phase_r;
  logic [ACC_W-1:0] acc_r;
  logic             en_raw_r;
  logic             clk_raw_r;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] phase_next_s;

  // Accumulator add with carry, and the phase value a realign must load
  // (the freshly written phase when this channel's phase is written now).
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, inc_r};
    if (phase_wr) begin
      phase_next_s = wr_data;
    end else begin
      phase_next_s = phase_r;
    end
  end

  // Channel registers: config, accumulator and raw outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_r     <= '0;
      phase_r   <= '0;
      acc_r     <= '0;
      en_raw_r  <= 1'b0;
      clk_raw_r <= 1'b0;
    end else begin
      if (inc_wr) begin
        inc_r <= wr_data;
      end
      if (phase_wr) begin
        phase_r <= wr_data;
      end
      if (realign) begin
        // The lock drops on this same edge, so the raw outputs are gated
        // off afterwards; no carry is reported for the realign edge.
        acc_r     <= phase_next_s;
        en_raw_r  <= 1'b0;
        clk_raw_r <= phase_next_s[ACC_W-1];
      end else begin
        acc_r     <= sum_s[ACC_W-1:0];
        en_raw_r  <= sum_s[ACC_W];
        clk_raw_r <= sum_s[ACC_W-1];
      end
    end
  end

  assign en_raw  = en_raw_r;
  assign clk_raw = clk_raw_r;

endmodule

// File: rtl/mf_clkgen.sv
// mf_clkgen: NUM_CLOCKS-channel fractional clock-enable generator.
// Ports:
//   refclk    in   single clock for all logic
//   rst       in   synchronous active-high reset
//   cfg_wr    in   config write strobe
//   cfg_sel   in   CFG_INC / CFG_PHASE register select
//   cfg_ch    in   target channel (writes to cfg_ch >= NUM_CLOCKS ignored)
//   cfg_data  in   value written
//   outclk_en out  per-channel one-cycle enable pulse, gated by locked
//   outclk    out  per-channel square wave (acc MSB), gated by locked
//   locked    out  high LOCK_CYCLES edges after reset release / last write
module mf_clkgen
  import mf_clkgen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 7,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic                  cfg_sel,
  input  logic [CH_IDX_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]      cfg_data,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic                  wr_valid_s;
  logic [NUM_CLOCKS-1:0] inc_wr_s;
  logic [NUM_CLOCKS-1:0] phase_wr_s;
  logic [NUM_CLOCKS-1:0] en_raw_s;
  logic [NUM_CLOCKS-1:0] clk_raw_s;
  lock_state_e           state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  locked_r;

  // Write decode: out-of-range channels produce no strobe and no realign.
  always_comb begin
    wr_valid_s = cfg_wr && ({1'b0, cfg_ch} < (CH_IDX_W + 1)'(NUM_CLOCKS));
    inc_wr_s   = '0;
    phase_wr_s = '0;
    for (int j = 0; j < NUM_CLOCKS; j++) begin
      inc_wr_s[j]   = wr_valid_s && (cfg_sel == CFG_INC)   && (cfg_ch == CH_IDX_W'(j));
      phase_wr_s[j] = wr_valid_s && (cfg_sel == CFG_PHASE) && (cfg_ch == CH_IDX_W'(j));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CLOCKS; g++) begin : g_ch
      mf_clkgen_nco #(
        .ACC_W (ACC_W)
      ) u_nco (
        .clk      (refclk),
        .rst      (rst),
        .realign  (wr_valid_s),
        .inc_wr   (inc_wr_s[g]),
        .phase_wr (phase_wr_s[g]),
        .wr_data  (cfg_data),
        .en_raw   (en_raw_s[g]),
        .clk_raw  (clk_raw_s[g])
      );
    end
  endgenerate

  // Lock FSM: count settle cycles after reset or any valid write.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r  <= UNLOCKED;
      cnt_r    <= '0;
      locked_r <= 1'b0;
    end else if (wr_valid_s) begin
      state_r  <= UNLOCKED;
      cnt_r    <= '0;
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        UNLOCKED: begin
          if (cnt_r == CNT_LAST) begin
            state_r  <= LOCKED;
            locked_r <= 1'b1;
          end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            locked_r <= 1'b0;
          end
        end
        LOCKED: begin
          locked_r <= 1'b1;
        end
        default: begin
          state_r  <= UNLOCKED;
          cnt_r    <= '0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  // Gating combines registers only, so the carry of edge t is visible
  // right after edge t and nothing reaches the outputs from the inputs.
  assign outclk_en = en_raw_s  & {NUM_CLOCKS{locked_r}};
  assign outclk    = clk_raw_s & {NUM_CLOCKS{locked_r}};
  assign locked    = locked_r;

endmodule

// File: tb/tb_mf_clkgen.sv
// tb_mf_clkgen: randomized and directed bench for mf_clkgen with an
// arithmetic reference model (NUM_CLOCKS=7, ACC_W=8, LOCK_CYCLES=16).
module tb_mf_clkgen;

  localparam int NCH  = 7;
  localparam int AW   = 8;
  localparam int LOCK = 16;

  logic           refclk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_wr = 1'b0;
  logic           cfg_sel = 1'b0;
  logic [3:0]     cfg_ch = 4'd0;
  logic [AW-1:0]  cfg_data = 8'd0;
  logic [NCH-1:0] outclk_en;
  logic [NCH-1:0] outclk;
  logic           locked;

  int n_checks = 0;
  int n_pass   = 0;

  mf_clkgen #(
    .NUM_CLOCKS  (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_sel   (cfg_sel),
    .cfg_ch    (cfg_ch),
    .cfg_data  (cfg_data),
    .outclk_en (outclk_en),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Between realigns each channel's accumulator is simply phase + k*inc,
  // k = edges since the last realign (reset or valid write).
  longint m_inc [NCH];
  longint m_ph  [NCH];
  longint edge_cnt = 0;
  longint anchor = 0;
  bit     model_valid = 1'b0;

  always @(posedge refclk) begin
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      anchor      <= edge_cnt + 1;
      model_valid <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_inc[i] <= 0;
        m_ph[i]  <= 0;
      end
    end else if (cfg_wr && cfg_ch < NCH) begin
      anchor <= edge_cnt + 1;
      if (cfg_sel) m_ph[cfg_ch]  <= longint'(cfg_data);
      else         m_inc[cfg_ch] <= longint'(cfg_data);
    end
  end

  always @(negedge refclk) begin
    if (model_valid) begin
      longint k, a1, a0;
      logic [NCH-1:0] e_en, e_clk;
      logic e_lock;
      k      = edge_cnt - anchor;
      e_lock = (k >= LOCK);
      e_en   = '0;
      e_clk  = '0;
      if (e_lock) begin
        for (int i = 0; i < NCH; i++) begin
          a1 = m_ph[i] + k * m_inc[i];
          a0 = m_ph[i] + (k - 1) * m_inc[i];
          e_en[i]  = ((a1 >> AW) != (a0 >> AW));
          e_clk[i] = a1[AW-1];
        end
      end
      check("model_locked", 64'(locked), 64'(e_lock));
      check("model_outclk_en", 64'(outclk_en), 64'(e_en));
      check("model_outclk", 64'(outclk), 64'(e_clk));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic sel, input logic [3:0] ch, input logic [AW-1:0] data);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
    @(posedge refclk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    do begin
      @(posedge refclk); #1;
      n++;
    end while (!locked && n < 100);
  endtask

  task automatic measure(input int ch, input int cycles,
                         output int cnt, output int mins, output int maxs, output int hi);
    int last;
    last = -1; cnt = 0; mins = 1000000; maxs = 0; hi = 0;
    for (int t = 0; t < cycles; t++) begin
      @(posedge refclk); #1;
      if (outclk[ch]) hi++;
      if (outclk_en[ch]) begin
        if (last >= 0) begin
          if (t - last < mins) mins = t - last;
          if (t - last > maxs) maxs = t - last;
        end
        last = t;
        cnt++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt, mins, maxs, hi, last3, lead_ok, en2_cnt, inv_bad;

    // Reset / lock
    repeat (3) begin @(posedge refclk); #1; end
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_outclk_en", 64'(outclk_en), 64'd0);
    check("reset_outclk", 64'(outclk), 64'd0);
    rst = 1'b0;
    wait_lock(n);
    check("lock_after_release", 64'(n), 64'd16);

    // Integer divide
    do_write(1'b0, 4'd0, 8'd64);
    wait_lock(n);
    check("lock_after_write", 64'(n), 64'd16);
    measure(0, 40, cnt, mins, maxs, hi);
    check("div4_count", 64'(cnt), 64'd10);
    check("div4_min", 64'(mins), 64'd4);
    check("div4_max", 64'(maxs), 64'd4);
    check("div4_high", 64'(hi), 64'd20);

    // Fractional
    do_write(1'b0, 4'd1, 8'd3);
    wait_lock(n);
    measure(1, 2560, cnt, mins, maxs, hi);
    check("frac_count", 64'(cnt), 64'd30);
    check("frac_min", 64'(mins), 64'd85);
    check("frac_max", 64'(maxs), 64'd86);

    // Phase realign
    do_write(1'b0, 4'd2, 8'd64);
    do_write(1'b1, 4'd2, 8'd0);
    do_write(1'b0, 4'd3, 8'd64);
    do_write(1'b1, 4'd3, 8'd128);
    wait_lock(n);
    last3 = -100; lead_ok = 0; en2_cnt = 0; inv_bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge refclk); #1;
      if (outclk[2] == outclk[3]) inv_bad++;
      if (outclk_en[3]) last3 = t;
      if (outclk_en[2]) begin
        en2_cnt++;
        if (t - last3 == 2) lead_ok++;
      end
    end
    check("phase_en2_count", 64'(en2_cnt), 64'd5);
    check("phase_lead2", 64'(lead_ok), 64'd5);
    check("phase_inverted", 64'(inv_bad), 64'd0);

    // Write during countdown
    do_write(1'b0, 4'd4, 8'd5);
    repeat (10) begin @(posedge refclk); #1; end
    check("countdown_unlocked", 64'(locked), 64'd0);
    do_write(1'b0, 4'd5, 8'd7);
    wait_lock(n);
    check("countdown_restart", 64'(n), 64'd16);

    // Invalid channel while locked
    do_write(1'b0, 4'd9, 8'd200);
    check("invalid_keeps_lock", 64'(locked), 64'd1);
    measure(0, 40, cnt, mins, maxs, hi);
    check("invalid_div4_min", 64'(mins), 64'd4);
    check("invalid_div4_max", 64'(maxs), 64'd4);

    // Randomized writes, invalid channels and resets
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        @(posedge refclk); #1;
        rst = 1'b0;
      end else begin
        do_write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(1, 40)) begin @(posedge refclk); #1; end
    end

    // Simultaneous rst and cfg_wr: reset wins
    rst = 1'b1;
    cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_ch = 4'd0; cfg_data = 8'd64;
    @(posedge refclk); #1;
    rst = 1'b0; cfg_wr = 1'b0;
    check("simul_locked", 64'(locked), 64'd0);
    wait_lock(n);
    check("simul_lock_delay", 64'(n), 64'd16);
    measure(0, 40, cnt, mins, maxs, hi);
    check("simul_no_pulses", 64'(cnt), 64'd0);
    check("simul_outclk", 64'(outclk), 64'd0);

    repeat (5) begin @(posedge refclk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mf_clkgen.md
# mf_clkgen

Parametrised multi-channel fractional clock-enable generator: the programmable successor of the fixed seven-output PLL wrapper. From one fast reference clock it derives NUM_CLOCKS independent phase-accumulator (NCO) channels. Each channel produces a single-cycle enable pulse and a near-50 % square wave, with runtime-programmable frequency and phase. A `locked` flag asserts after a settle period and drops on every reconfiguration. Core logic uses the enables as clock enables in the `refclk` domain instead of consuming extra PLL outputs.

## Interface
- NUM_CLOCKS, 7: number of output channels (1..16).
- ACC_W, 32: accumulator/increment/phase width (8..32).
- LOCK_CYCLES, 1024: settle cycles before `locked` asserts (>= 2).
- refclk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- cfg_wr  in  1  config write strobe, one cycle per write.
- cfg_sel  in  1  0 = increment register, 1 = phase register.
- cfg_ch  in  4  target channel index.
- cfg_data  in  ACC_W  value written.
- outclk_en  out  NUM_CLOCKS  per-channel one-cycle enable pulse.
- outclk  out  NUM_CLOCKS  per-channel square wave (accumulator MSB).
- locked  out  1  outputs valid and phase-aligned.

## Operation
- Per channel i: registers inc[i], phase[i], acc[i], all ACC_W bits. Output frequency = f_refclk * inc[i] / 2^ACC_W.
- Every cycle: {carry, sum} = acc[i] + inc[i], computed as an (ACC_W+1)-bit add. Then acc[i] <= sum (wraps mod 2^ACC_W), en_raw[i] <= carry, clk_raw[i] <= sum[ACC_W-1].
- inc[i] = 0: channel stopped. No enables; outclk is constant at phase[i] MSB.
- inc[i] >= 2^(ACC_W-1) is legal. outclk then aliases, but enables remain exact.
- Valid write (cfg_wr=1, cfg_ch < NUM_CLOCKS) updates inc or phase of that channel. In the same edge it realigns the whole bank: every acc[j] <= phase[j], using the new value for the written channel. It also clears the lock counter and `locked`.
- Invalid write (cfg_ch >= NUM_CLOCKS) is ignored entirely: no register change, no realign, no lock loss.
- Lock FSM states:
  - UNLOCKED: counter runs 0..LOCK_CYCLES-1. On the edge where the counter equals LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: hold until a valid write (go to UNLOCKED, counter 0) or rst.
- Output gating: outclk_en = en_raw & {locked}; outclk = clk_raw & {locked}. Both are registered, with no combinational path from inputs.

## Timing
- Reset values: inc = 0, phase = 0, acc = 0, counter = 0, locked = 0, outclk_en = 0, outclk = 0.
- Priority: rst beats cfg_wr in the same cycle; the write is lost.
- `locked` rises exactly LOCK_CYCLES edges after the first edge with rst=0. After a valid write, it rises LOCK_CYCLES edges after the write edge.
- A valid write during the UNLOCKED countdown restarts the countdown from 0.
- Enable latency: the carry from the add at edge t appears on outclk_en after edge t, high for exactly one cycle.
- After realign at edge w, the first carry for channel i occurs at edge w + ceil((2^ACC_W - phase[i]) / inc[i]).
- Accumulators run throughout UNLOCKED, so phase relation at lock is deterministic.
- Reset mid-operation clears everything in one edge, with no partial pulses afterwards.

## Structure
- Package mf_clkgen_pkg holds:
  - cfg_sel encodings CFG_INC = 1'b0, CFG_PHASE = 1'b1;
  - the lock FSM state enum {UNLOCKED, LOCKED};
  - a channel-index width constant of 4.
- Sub-module mf_clkgen_nco: one channel. It holds the inc/phase/acc registers, takes a realign input and write strobes, and outputs en_raw/clk_raw. It is instantiated NUM_CLOCKS times in a generate loop.
- Top level holds write decode, lock FSM/counter and output gating.

## Test plan
All scenarios use ACC_W=8 and LOCK_CYCLES=16 unless noted.
- Reset/lock: hold rst 3 cycles, then release. Expect all outputs 0; `locked` rises on exactly the 16th edge after release; outclk_en stays 0 throughout (inc = 0).
- Integer divide: write ch0 inc=64. Expect `locked` high 16 edges later. Then expect outclk_en[0] to pulse every 4 cycles and outclk[0] to run 2 high / 2 low.
- Fractional: ch1 inc=3 for 2560 cycles after lock. Expect exactly 30 outclk_en[1] pulses, with spacing of 85 or 86 cycles.
- Phase realign:
  - ch2 inc=64, phase=0; ch3 inc=64, phase=128.
  - Expect outclk_en[3] to lead outclk_en[2] by 2 cycles after lock.
  - Expect outclk[2] and outclk[3] to be inverted.
- Write during countdown / invalid write:
  - A valid write 10 cycles into UNLOCKED delays `locked` to 16 edges after that write.
  - A write with cfg_ch=9 (NUM_CLOCKS=7) while LOCKED leaves `locked` high and pulse spacing unchanged.
- Simultaneous rst and cfg_wr: expect the reset state, with inc unchanged at 0.
